// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg -- shared definitions for the MEM pipeline stage.
//   Bus command encodings, access-size encodings, mem_ctrl bit positions
//   and the FSM state type. Legacy sys_defs-style macros are provided as
//   well for code that still uses the back-ticked names.
// Optional build macro consumed by mem_stage: MEM_MISALIGN_CHK_EN.

`ifndef BUS_NONE
`define BUS_NONE  2'b00
`define BUS_LOAD  2'b01
`define BUS_STORE 2'b10
`endif

`ifndef MEM_B
`define MEM_B 2'b00
`define MEM_H 2'b01
`define MEM_W 2'b10
`endif

package mem_stage_pkg;

    // Bus commands
    localparam logic [1:0] BUS_NONE  = 2'b00;
    localparam logic [1:0] BUS_LOAD  = 2'b01;
    localparam logic [1:0] BUS_STORE = 2'b10;

    // Access sizes (mem_ctrl[1:0])
    localparam logic [1:0] MEM_B = 2'b00;
    localparam logic [1:0] MEM_H = 2'b01;
    localparam logic [1:0] MEM_W = 2'b10;

    // mem_ctrl bit positions
    localparam int CTRL_RD  = 4;
    localparam int CTRL_WR  = 3;
    localparam int CTRL_UNS = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } mem_state_t;

endpackage

// File: rtl/mem_align.sv
// mem_align -- purely combinational lane logic for the MEM stage.
//   Store side: replicates store data into byte lanes and builds byte
//   enables. Load side: extracts the addressed byte/half from the bus word
//   and sign- or zero-extends it.
// Ports:
//   st_addr_lo  in  2   low address bits of the store/request
//   st_size     in  2   access size of the request
//   st_din      in  32  store data, right-justified
//   st_data     out 32  lane-replicated store data
//   st_be       out 4   byte enables
//   ld_addr_lo  in  2   low address bits of the load being completed
//   ld_size     in  2   access size of the load being completed
//   ld_uns      in  1   zero-extend when set
//   ld_word     in  32  word returned by memory
//   ld_data     out 32  formatted load result
// Sizes outside B/H are treated as a full word.

module mem_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  st_addr_lo,
    input  logic [1:0]  st_size,
    input  logic [31:0] st_din,
    output logic [31:0] st_data,
    output logic [3:0]  st_be,
    input  logic [1:0]  ld_addr_lo,
    input  logic [1:0]  ld_size,
    input  logic        ld_uns,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_data = st_din;
        st_be   = 4'b1111;
        case (st_size)
            MEM_B: begin
                st_data = {4{st_din[7:0]}};
                st_be   = 4'b0001 << st_addr_lo;
            end
            // addr[0] is dropped: halves always land on an aligned lane pair
            MEM_H: begin
                st_data = {2{st_din[15:0]}};
                st_be   = 4'b0011 << {st_addr_lo[1], 1'b0};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = ld_word[{ld_addr_lo, 3'b000} +: 8];
        ld_half = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
        case (ld_size)
            MEM_B:   ld_data = {{24{~ld_uns & ld_byte[7]}}, ld_byte};
            MEM_H:   ld_data = {{16{~ld_uns & ld_half[15]}}, ld_half};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage -- MEM pipeline stage with a single-outstanding request/ack bus.
//   Non-memory ops pass the ALU result straight through. Loads/stores are
//   issued combinationally from IDLE; if memory does not ack in that cycle
//   the request is held in registered copies (ACCESS) and the pipeline is
//   stalled until ack or until TIMEOUT_CYCLES elapse (DONE, MEM_err pulse).
// Ports:
//   clk, rst (sync, active-high)
//   EX_MEM_alu_res/mem_din/vld/mem_ctrl   EX/MEM register contents
//   mem2proc_ack/data                      memory response
//   proc2mem_cmd/addr/data/be              memory request
//   MEM_data/MEM_vld                       stage result
//   MEM_stall                              freeze upstream stages
//   MEM_err                                one-cycle error pulse
// Build option: define MEM_MISALIGN_CHK_EN to reject misaligned H/W
//   accesses with an immediate MEM_err instead of truncating the address.

module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] EX_MEM_alu_res,
    input  logic [31:0] EX_MEM_mem_din,
    input  logic        EX_MEM_vld,
    input  logic [4:0]  EX_MEM_mem_ctrl,
    input  logic        mem2proc_ack,
    input  logic [31:0] mem2proc_data,
    output logic [1:0]  proc2mem_cmd,
    output logic [31:0] proc2mem_addr,
    output logic [31:0] proc2mem_data,
    output logic [3:0]  proc2mem_be,
    output logic [31:0] MEM_data,
    output logic        MEM_vld,
    output logic        MEM_stall,
    output logic        MEM_err
);

    mem_state_t state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic rd, wr, is_mem, req, mis;
    assign rd     = EX_MEM_mem_ctrl[CTRL_RD];
    assign wr     = EX_MEM_mem_ctrl[CTRL_WR];
    assign is_mem = EX_MEM_vld & (rd ^ wr);

`ifdef MEM_MISALIGN_CHK_EN
    assign mis = is_mem &
                 (((EX_MEM_mem_ctrl[1:0] == MEM_H) & EX_MEM_alu_res[0]) |
                  ((EX_MEM_mem_ctrl[1:0] == MEM_W) & (EX_MEM_alu_res[1:0] != 2'b00)));
`else
    assign mis = 1'b0;
`endif

    assign req = is_mem & ~mis;

    // Request held across ACCESS (data path, not reset)
    logic [1:0]  cmd_p1;
    logic [31:0] addr_p1, data_p1;
    logic [3:0]  be_p1;
    logic [1:0]  lo_p1, size_p1;
    logic        uns_p1;
    logic        capture;

    logic [31:0] st_data, ld_data;
    logic [3:0]  st_be;
    logic        in_access;
    assign in_access = (state == ST_ACCESS);

    mem_align u_align (
        .st_addr_lo (EX_MEM_alu_res[1:0]),
        .st_size    (EX_MEM_mem_ctrl[1:0]),
        .st_din     (EX_MEM_mem_din),
        .st_data    (st_data),
        .st_be      (st_be),
        .ld_addr_lo (in_access ? lo_p1   : EX_MEM_alu_res[1:0]),
        .ld_size    (in_access ? size_p1 : EX_MEM_mem_ctrl[1:0]),
        .ld_uns     (in_access ? uns_p1  : EX_MEM_mem_ctrl[CTRL_UNS]),
        .ld_word    (mem2proc_data),
        .ld_data    (ld_data)
    );

    logic [1:0] cmd_c;
    logic [3:0] be_c;
    logic       vld_c, stall_c, err_c;

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        capture       = 1'b0;
        cmd_c         = BUS_NONE;
        be_c          = 4'b0000;
        proc2mem_addr = {EX_MEM_alu_res[31:2], 2'b00};
        proc2mem_data = st_data;
        MEM_data      = EX_MEM_alu_res;
        vld_c         = 1'b0;
        stall_c       = 1'b0;
        err_c         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mis) begin
                    err_c = 1'b1;
                end else if (req) begin
                    cmd_c = rd ? BUS_LOAD : BUS_STORE;
                    be_c  = st_be;
                    if (mem2proc_ack) begin
                        vld_c    = 1'b1;
                        MEM_data = rd ? ld_data : 32'd0;
                    end else begin
                        stall_c   = 1'b1;
                        capture   = 1'b1;
                        state_nxt = ST_ACCESS;
                        cnt_nxt   = CNT_W'(1);
                    end
                end else if (!rd && !wr) begin
                    vld_c = EX_MEM_vld;
                end
            end
            ST_ACCESS: begin
                cmd_c         = cmd_p1;
                be_c          = be_p1;
                proc2mem_addr = addr_p1;
                proc2mem_data = data_p1;
                if (mem2proc_ack) begin
                    vld_c     = 1'b1;
                    MEM_data  = (cmd_p1 == BUS_LOAD) ? ld_data : 32'd0;
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    stall_c = 1'b1;
                    if (cnt == CNT_W'(TIMEOUT_CYCLES)) begin
                        state_nxt = ST_DONE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                err_c     = 1'b1;
                MEM_data  = 32'd0;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Control outputs are forced quiet while reset is held; stall also
    // requires a valid instruction in EX/MEM.
    assign proc2mem_cmd = rst ? BUS_NONE : cmd_c;
    assign proc2mem_be  = rst ? 4'b0000  : be_c;
    assign MEM_vld      = vld_c & ~rst;
    assign MEM_stall    = stall_c & EX_MEM_vld & ~rst;
    assign MEM_err      = err_c & ~rst;

    // ---- stage boundary: FSM control registers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // ---- stage boundary: held request copies ----
    always_ff @(posedge clk) begin
        if (capture) begin
            cmd_p1  <= cmd_c;
            addr_p1 <= {EX_MEM_alu_res[31:2], 2'b00};
            data_p1 <= st_data;
            be_p1   <= st_be;
            lo_p1   <= EX_MEM_alu_res[1:0];
            size_p1 <= EX_MEM_mem_ctrl[1:0];
            uns_p1  <= EX_MEM_mem_ctrl[CTRL_UNS];
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_res, mem_din, mem_rdata;
    logic        vld, ack;
    logic [4:0]  ctrl;
    logic [1:0]  cmd;
    logic [31:0] addr, wdata, mdata;
    logic [3:0]  be;
    logic        mvld, stall, err;

    int total = 0;
    int bad   = 0;
    int n;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .EX_MEM_alu_res  (alu_res),
        .EX_MEM_mem_din  (mem_din),
        .EX_MEM_vld      (vld),
        .EX_MEM_mem_ctrl (ctrl),
        .mem2proc_ack    (ack),
        .mem2proc_data   (mem_rdata),
        .proc2mem_cmd    (cmd),
        .proc2mem_addr   (addr),
        .proc2mem_data   (wdata),
        .proc2mem_be     (be),
        .MEM_data        (mdata),
        .MEM_vld         (mvld),
        .MEM_stall       (stall),
        .MEM_err         (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are then driven, and outputs checked #1 later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; vld = 1'b0; ctrl = 5'd0; ack = 1'b0;
        alu_res = 32'd0; mem_din = 32'd0; mem_rdata = 32'd0;
        tick(); tick();
        #1;
        chk("rst_cmd",   cmd,   BUS_NONE);
        chk("rst_be",    be,    4'b0000);
        chk("rst_stall", stall, 1'b0);
        chk("rst_vld",   mvld,  1'b0);
        chk("rst_err",   err,   1'b0);
        rst = 1'b0;
        tick();

        // ALU pass-through
        vld = 1'b1; ctrl = 5'b00000; alu_res = 32'h1234_5678;
        #1;
        chk("pt_data",  mdata, 32'h1234_5678);
        chk("pt_vld",   mvld,  1'b1);
        chk("pt_stall", stall, 1'b0);
        chk("pt_cmd",   cmd,   BUS_NONE);

        // rd+wr together is a NOP
        ctrl = 5'b11010;
        #1;
        chk("ill_vld",   mvld,  1'b0);
        chk("ill_cmd",   cmd,   BUS_NONE);
        chk("ill_stall", stall, 1'b0);
        tick();

        // Store byte, addr 0x103, ack on the fourth cycle
        ctrl = 5'b01000; alu_res = 32'h0000_0103; mem_din = 32'h0000_00AB;
        #1;
        chk("sb_cmd",   cmd,   BUS_STORE);
        chk("sb_addr",  addr,  32'h0000_0100);
        chk("sb_data",  wdata, 32'hABAB_ABAB);
        chk("sb_be",    be,    4'b1000);
        chk("sb_stall0", stall, 1'b1);
        tick(); #1;
        chk("sb_stall1", stall, 1'b1);
        chk("sb_hold_addr", addr, 32'h0000_0100);
        chk("sb_hold_data", wdata, 32'hABAB_ABAB);
        chk("sb_hold_be",   be,    4'b1000);
        chk("sb_vld1",   mvld,  1'b0);
        tick(); #1;
        chk("sb_stall2", stall, 1'b1);
        tick();
        ack = 1'b1;
        #1;
        chk("sb_ack_stall", stall, 1'b0);
        chk("sb_ack_vld",   mvld,  1'b1);
        chk("sb_ack_data",  mdata, 32'd0);
        tick();
        ack = 1'b0; ctrl = 5'b00000; vld = 1'b0;
        #1;
        chk("sb_idle_cmd", cmd, BUS_NONE);
        tick();

        // Load half signed, same-cycle ack
        vld = 1'b1; ctrl = 5'b10001; alu_res = 32'h0000_0202;
        mem_rdata = 32'h8001_0000; ack = 1'b1;
        #1;
        chk("lh_cmd",   cmd,   BUS_LOAD);
        chk("lh_addr",  addr,  32'h0000_0200);
        chk("lh_data",  mdata, 32'hFFFF_8001);
        chk("lh_stall", stall, 1'b0);
        chk("lh_vld",   mvld,  1'b1);
        tick();

        // Load byte unsigned, same-cycle ack
        ctrl = 5'b10100; alu_res = 32'h0000_0001; mem_rdata = 32'h0000_F500;
        #1;
        chk("lbu_data",  mdata, 32'h0000_00F5);
        chk("lbu_stall", stall, 1'b0);
        tick();

        // Load word, same-cycle ack
        ctrl = 5'b10010; alu_res = 32'h0000_0010; mem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("lw_data", mdata, 32'hDEAD_BEEF);
        tick();

        // Load byte signed through ACCESS: ack one cycle late
        ack = 1'b0; ctrl = 5'b10000; alu_res = 32'h0000_0303; mem_rdata = 32'h0;
        #1;
        chk("lb_stall0", stall, 1'b1);
        tick();
        ack = 1'b1; mem_rdata = 32'h8000_0000;
        #1;
        chk("lb_data", mdata, 32'hFFFF_FF80);
        chk("lb_vld",  mvld,  1'b1);
        tick();

        // Store half / word lanes, same-cycle ack
        ctrl = 5'b01001; alu_res = 32'h0000_0002; mem_din = 32'h1234_BEEF;
        #1;
        chk("sh_data", wdata, 32'hBEEF_BEEF);
        chk("sh_be",   be,    4'b1100);
        ctrl = 5'b01010; alu_res = 32'h0000_0007;
        #1;
        chk("sw_data", wdata, 32'h1234_BEEF);
        chk("sw_be",   be,    4'b1111);
        chk("sw_addr", addr,  32'h0000_0004);
        tick();

        // Timeout: load with no ack
        ack = 1'b0; ctrl = 5'b10010; alu_res = 32'h0000_0040;
        #1;
        n = 0;
        while (stall && n < 40) begin
            n++;
            tick(); #1;
        end
        chk("to_stall_cycles", n, TO + 1);
        ack = 1'b1;
        #1;
        chk("to_err",   err,   1'b1);
        chk("to_stall", stall, 1'b0);
        chk("to_vld",   mvld,  1'b0);
        chk("to_cmd",   cmd,   BUS_NONE);
        tick();
        ack = 1'b0; vld = 1'b0; ctrl = 5'b00000;
        #1;
        chk("to_err_pulse", err, 1'b0);
        chk("to_idle_cmd",  cmd, BUS_NONE);
        tick();

        // Reset during ACCESS
        vld = 1'b1; ctrl = 5'b10010; alu_res = 32'h0000_0080;
        tick(); #1;
        chk("ra_stall", stall, 1'b1);
        chk("ra_cmd",   cmd,   BUS_LOAD);
        rst = 1'b1; vld = 1'b0; ctrl = 5'b00000;
        tick();
        rst = 1'b0;
        #1;
        chk("ra_cmd_after",   cmd,   BUS_NONE);
        chk("ra_stall_after", stall, 1'b0);
        ack = 1'b1; mem_rdata = 32'h5555_5555;
        #1;
        chk("ra_stray_vld", mvld, 1'b0);
        chk("ra_stray_cmd", cmd,  BUS_NONE);
        tick();
        ack = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of execute. It consumes the EX/MEM-registered ALU result, store data, valid bit and memory-control bits, and performs loads and stores over a single-outstanding request/ack memory bus.
- Produces the MEM result that feeds the forwarding mux (MEM_data) and the MEM/WB register.
- Stalls the pipeline while a memory access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 64, max cycles waiting for mem2proc_ack before the access is abandoned and MEM_err is raised
- CNT_W, 7, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- EX_MEM_alu_res  in  32  address for mem ops, result otherwise
- EX_MEM_mem_din  in  32  store data (unaligned, in low bytes)
- EX_MEM_vld  in  1  instruction valid
- EX_MEM_mem_ctrl  in  5  [4]=rd, [3]=wr, [2]=unsigned, [1:0]=size (`MEM_B/`MEM_H/`MEM_W)
- mem2proc_ack  in  1  memory completed the request this cycle
- mem2proc_data  in  32  read word, valid with ack
- proc2mem_cmd  out  2  `BUS_NONE/`BUS_LOAD/`BUS_STORE
- proc2mem_addr  out  32  word-aligned address {alu_res[31:2],2'b00}
- proc2mem_data  out  32  store data replicated into byte lanes
- proc2mem_be  out  4  byte enables
- MEM_data  out  32  stage result (load data or pass-through ALU result)
- MEM_vld  out  1  result valid this cycle
- MEM_stall  out  1  freeze IF/ID/EX and EX/MEM register
- MEM_err  out  1  one-cycle pulse: bus timeout (or misalign, see option)

Behaviour:
- Reset: state=IDLE, counter=0. proc2mem_cmd=`BUS_NONE, be=0, MEM_stall=0, MEM_vld=0, MEM_err=0.
- Non-memory op (rd=wr=0): MEM_data=EX_MEM_alu_res and MEM_vld=EX_MEM_vld, combinational, zero added latency, no stall.
- rd and wr both set is illegal: treat as a NOP, MEM_vld=0.
- FSM states IDLE, ACCESS, DONE:
  - IDLE: a valid mem op drives cmd/addr/data/be combinationally and asserts MEM_stall.
    - If ack arrives in the same cycle, complete with no state change.
    - Otherwise go to ACCESS next cycle; counter=1.
  - ACCESS: hold cmd/addr/data/be stable (registered copies) and keep MEM_stall=1.
    - On ack: MEM_stall=0, MEM_vld=1, MEM_data=formatted load (stores: MEM_data=0). Then go to IDLE.
    - Counter increments each cycle without ack. When counter==TIMEOUT_CYCLES: go to DONE.
  - DONE: cmd=`BUS_NONE, MEM_err=1, MEM_vld=0, MEM_stall=0 for one cycle, then go to IDLE.
    - A late ack in DONE or IDLE with no request is ignored.
- Store lane mapping:
  - B: data={4{din[7:0]}}, be=4'b0001<<addr[1:0].
  - H: data={2{din[15:0]}}, be=4'b0011<<{addr[1],1'b0}.
  - W: data=din, be=4'b1111.
- Load formatting:
  - Select byte/half by addr[1:0] / addr[1].
  - Sign-extend unless unsigned=1; W is unchanged.
- Misaligned H/W without the option: addr[0] (or addr[1:0] for W) is ignored and the aligned lanes are used.
- MEM_stall is never asserted when EX_MEM_vld=0.
- rst mid-access: return to IDLE and drop cmd next edge; a pending ack is ignored.

Optional Feature:
- Macro MEM_MISALIGN_CHK_EN.
- Defined: misaligned H (addr[0]=1) or W (addr[1:0]!=0) issues no bus command. Result is MEM_err=1 and MEM_vld=0 in the same cycle, with no stall.
- Undefined: no check; the alignment truncation above applies.

Decomposition:
- Shared sys_defs additions: `BUS_NONE/`BUS_LOAD/`BUS_STORE, `MEM_B/`MEM_H/`MEM_W, mem_ctrl bit positions.
- One natural sub-module: mem_align (pure combinational). It covers store lane replication, byte enables and load extract/extend. The FSM stays in mem_stage.

Test Plan:
- ALU pass-through: vld=1, ctrl=0, alu_res=0x1234_5678 -> MEM_data=0x1234_5678, MEM_vld=1, stall=0, cmd=NONE.
- Store byte, addr=0x103, din=0xAB, ack after 3 cycles -> addr=0x100, data=0xABABABAB, be=4'b1000; stall held 3 cycles; MEM_vld=1 on the ack cycle.
- Load half signed, addr=0x202, mem data=0x8001_0000, same-cycle ack -> MEM_data=0xFFFF_8001, no stall cycle.
- Load byte unsigned, addr=0x001, data=0x0000_F500 -> MEM_data=0x0000_00F5.
- Load with no ack -> stall for exactly TIMEOUT_CYCLES+1 cycles, one-cycle MEM_err pulse, cmd returns to NONE.
- rst asserted during ACCESS -> next cycle cmd=NONE, stall=0; a subsequent stray ack produces no MEM_vld.
